// File: rtl/vxe_axi_biu_req.sv
// AXI BIU request stage: pops write/read requests from the switch and issues each
// as a single-beat 64-bit AXI4 transaction, limiting outstanding transactions per direction.
module vxe_axi_biu_req #(
    parameter int MAX_OUTST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  biu_awcid,
    input  logic [39:0] biu_awaddr,
    input  logic [63:0] biu_awdata,
    input  logic [7:0]  biu_awstrb,
    input  logic        biu_awvalid,
    output logic        biu_awpop,
    input  logic [5:0]  biu_arcid,
    input  logic [39:0] biu_araddr,
    input  logic        biu_arvalid,
    output logic        biu_arpop,
    output logic [5:0]  m_awid,
    output logic [39:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    output logic [5:0]  m_arid,
    output logic [39:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic        i_wr_done,
    input  logic        i_rd_done,
    output logic [3:0]  o_wr_outst,
    output logic [3:0]  o_rd_outst,
    output logic        o_err
);
    localparam logic [1:0] W_IDLE = 2'd0, W_POP = 2'd1, W_CAPT = 2'd2, W_SEND = 2'd3;
    localparam logic [1:0] R_IDLE = 2'd0, R_POP = 2'd1, R_CAPT = 2'd2, R_SEND = 2'd3;
    localparam logic [3:0] LP_MAX = 4'(MAX_OUTST);

    logic [1:0]  r_wst, r_rst_st;
    logic        r_awpop, r_arpop, r_awvalid, r_wvalid, r_arvalid;
    logic [5:0]  r_awid, r_arid;
    logic [39:0] r_awaddr, r_araddr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic [3:0]  r_wr_outst, r_rd_outst;
    logic        r_err;

    logic w_aw_hs, w_w_hs, w_ar_hs, w_wr_can, w_rd_can;

    // Simultaneous increment and decrement cancel; a decrement at zero is absorbed.
    function automatic logic [3:0] f_next_cnt(input logic [3:0] cnt, input logic inc, input logic dec);
        case ({inc, dec})
            2'b10:   return cnt + 4'd1;
            2'b01:   return (cnt == 4'd0) ? cnt : cnt - 4'd1;
            default: return cnt;
        endcase
    endfunction

    assign w_aw_hs  = r_awvalid & m_awready;
    assign w_w_hs   = r_wvalid & m_wready;
    assign w_ar_hs  = r_arvalid & m_arready;
    assign w_wr_can = biu_awvalid && (r_wr_outst < LP_MAX);
    assign w_rd_can = biu_arvalid && (r_rd_outst < LP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wst     <= W_IDLE;
            r_awpop   <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wst)
                W_IDLE: if (w_wr_can) begin
                    r_wst   <= W_POP;
                    r_awpop <= 1'b1;
                end
                W_POP: begin
                    r_awpop <= 1'b0;
                    r_wst   <= W_CAPT;
                end
                W_CAPT: begin
                    r_awid    <= biu_awcid;
                    r_awaddr  <= biu_awaddr;
                    r_wdata   <= biu_awdata;
                    r_wstrb   <= biu_awstrb;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_wst     <= W_SEND;
                end
                W_SEND: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    // Exit once neither channel still has a beat pending after this edge.
                    if ((!r_awvalid || m_awready) && (!r_wvalid || m_wready))
                        r_wst <= W_IDLE;
                end
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_st  <= R_IDLE;
            r_arpop   <= 1'b0;
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
        end else begin
            case (r_rst_st)
                R_IDLE: if (w_rd_can) begin
                    r_rst_st <= R_POP;
                    r_arpop  <= 1'b1;
                end
                R_POP: begin
                    r_arpop  <= 1'b0;
                    r_rst_st <= R_CAPT;
                end
                R_CAPT: begin
                    r_arid    <= biu_arcid;
                    r_araddr  <= biu_araddr;
                    r_arvalid <= 1'b1;
                    r_rst_st  <= R_SEND;
                end
                R_SEND: if (w_ar_hs) begin
                    r_arvalid <= 1'b0;
                    r_rst_st  <= R_IDLE;
                end
                default: r_rst_st <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_outst <= '0;
            r_rd_outst <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_outst <= f_next_cnt(r_wr_outst, w_aw_hs, i_wr_done);
            r_rd_outst <= f_next_cnt(r_rd_outst, w_ar_hs, i_rd_done);
            if ((i_wr_done && !w_aw_hs && r_wr_outst == 4'd0) ||
                (i_rd_done && !w_ar_hs && r_rd_outst == 4'd0))
                r_err <= 1'b1;
        end
    end

    assign biu_awpop  = r_awpop;
    assign biu_arpop  = r_arpop;
    assign m_awid     = r_awid;
    assign m_awaddr   = r_awaddr;
    assign m_awlen    = 8'd0;
    assign m_awsize   = 3'b011;
    assign m_awburst  = 2'b01;
    assign m_awvalid  = r_awvalid;
    assign m_wdata    = r_wdata;
    assign m_wstrb    = r_wstrb;
    assign m_wlast    = 1'b1;
    assign m_wvalid   = r_wvalid;
    assign m_arid     = r_arid;
    assign m_araddr   = r_araddr;
    assign m_arlen    = 8'd0;
    assign m_arsize   = 3'b011;
    assign m_arburst  = 2'b01;
    assign m_arvalid  = r_arvalid;
    assign o_wr_outst = r_wr_outst;
    assign o_rd_outst = r_rd_outst;
    assign o_err      = r_err;
endmodule
